mips_multicycle_ctrl: RTL



---
 rtl/mips_ctrl_pkg.sv | 54 +++++
 rtl/mips_op_decode.sv | 27 ++
 rtl/mips_multicycle_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit.
// Encodings here are the contract between the FSM and the datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    JR     = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic lw;
    logic sw;
    logic rtype;
    logic jr;
    logic beq;
    logic j;
    logic addi;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mips_op_decode.sv
// Combinational opcode classifier; yields exactly one class bit.
// JR is split out of R-type so the FSM can skip register writeback.
module mips_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) cls.jr = 1'b1;
        else                   cls.rtype = 1'b1;
      end
      OP_LW:   cls.lw = 1'b1;
      OP_SW:   cls.sw = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j = 1'b1;
      OP_ADDI: cls.addi = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM driving the shared datapath.
// Outputs are forced low while reset is held so requests drop at once.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_we,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t    cur;
  state_t    nxt;
  op_class_t cls;

  mips_op_decode u_dec (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (cls.lw || cls.sw) nxt = MEMADR;
        else if (cls.jr)      nxt = JR;
        else if (cls.rtype)   nxt = EXEC;
        else if (cls.beq)     nxt = BRANCH;
        else if (cls.j)       nxt = JUMP;
        else if (cls.addi)    nxt = ADDIEX;
        else                  nxt = FETCH;
      end
      MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (cur)
        FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        DECODE: begin
          alu_src_b  = SRCB_IMM_SH;
          illegal_op = cls.illegal;
        end
        MEMADR, ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEMRD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
        end
        MEMWB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        ALUWB: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = PC_ALUOUT;
          pc_we     = zero;
        end
        JUMP: begin
          pc_src = PC_JUMP;
          pc_we  = 1'b1;
        end
        JR: begin
          pc_src = PC_RS;
          pc_we  = 1'b1;
        end
        ADDIWB: reg_we = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
